// File: rtl/product_bcd_converter.sv
// Iterative double-dabble converter: captures a WIDTH-bit product and emits sign plus packed BCD.
// Optional two's-complement input handling is enabled by defining PRODUCT_BCD_SIGNED_EN.
module product_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      product_in,
   output logic                  busy,
   output logic                  done,
   output logic                  valid,
   output logic                  sign_out,
   output logic [4*DIGITS-1:0]   bcd_out
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] mag;
   logic [BW-1:0]    acc;
   logic [BW-1:0]    acc_adj;
   logic [BW-1:0]    acc_next;
   logic [CW-1:0]    cnt;
   logic             sign_flag;
   logic             sign_in;

`ifdef PRODUCT_BCD_SIGNED_EN
   // Negation stays WIDTH bits wide so the most negative value maps to its unsigned magnitude.
   assign sign_in = product_in[WIDTH-1];
   assign mag     = sign_in ? ((~product_in) + WIDTH'(1)) : product_in;
`else
   assign sign_in = 1'b0;
   assign mag     = product_in;
`endif

   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   assign acc_next = {acc_adj[BW-2:0], sr[WIDTH-1]};

   // Handshake: start is honoured only in IDLE (busy=0); while busy=1 start and product_in are
   // ignored. done pulses for one cycle as bcd_out/sign_out/valid update together.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         sr        <= '0;
         acc       <= '0;
         cnt       <= '0;
         sign_flag <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         sign_out  <= 1'b0;
         bcd_out   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr        <= mag;
                  sign_flag <= sign_in;
                  acc       <= '0;
                  cnt       <= CW'(WIDTH);
                  busy      <= 1'b1;
                  state     <= CONVERT;
               end
            end
            CONVERT: begin
               acc <= acc_next;
               sr  <= {sr[WIDTH-2:0], 1'b0};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bcd_out  <= acc_next;
                  sign_out <= sign_flag;
                  valid    <= 1'b1;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomised and directed bench for product_bcd_converter against an arithmetic BCD model.
// Build with PRODUCT_BCD_SIGNED_EN defined to exercise the signed variant.
module tb_product_bcd_converter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] product_in;
   logic        busy;
   logic        done;
   logic        valid;
   logic        sign_out;
   logic [19:0] bcd_out;

   int total = 0;
   int bad   = 0;
   logic [20:0] exp_q[$];

   product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .product_in (product_in),
      .busy       (busy),
      .done       (done),
      .valid      (valid),
      .sign_out   (sign_out),
      .bcd_out    (bcd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: {sign, packed BCD} from decimal arithmetic on the input value.
   function automatic logic [20:0] model(input logic [15:0] v);
      int m;
      logic s;
      logic [19:0] b;
`ifdef PRODUCT_BCD_SIGNED_EN
      s = v[15];
      m = s ? (65536 - int'(v)) : int'(v);
`else
      s = 1'b0;
      m = int'(v);
`endif
      b = '0;
      for (int i = 0; i < 5; i++) begin
         b[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {s, b};
   endfunction

   // One conversion; glitch_at >= 0 pulses start with a different value during CONVERT.
   task automatic do_conv(input logic [15:0] val, input int glitch_at);
      logic [20:0] prev;
      logic [20:0] exp;
      int cyc;
      @(negedge clk);
      start = 1'b1;
      product_in = val;
      exp_q.push_back(model(val));
      prev = {sign_out, bcd_out};
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_e0", 32'(busy), 32'd1);
      cyc = 0;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (!done) begin
            check("busy_hold", 32'(busy), 32'd1);
            check("result_hold", 32'({sign_out, bcd_out}), 32'(prev));
         end
         if (cyc == glitch_at) begin
            start = 1'b1;
            product_in = 16'h1234;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      exp = exp_q.pop_front();
      if (!done) begin
         check("done_timeout", 32'(cyc), 32'd16);
      end else begin
         check("latency", 32'(cyc), 32'd16);
         check("busy_end", 32'(busy), 32'd0);
         check("valid_end", 32'(valid), 32'd1);
         check("result", 32'({sign_out, bcd_out}), 32'(exp));
         @(posedge clk); #1;
         check("done_pulse", 32'(done), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int seen;
      reset_n = 1'b0;
      start = 1'b0;
      product_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_bcd", 32'(bcd_out), 32'd0);
      check("rst_sign", 32'(sign_out), 32'd0);

      do_conv(16'hFFEB, -1);
      do_conv(16'hFFFF, -1);
      do_conv(16'h8000, -1);
      do_conv(16'h0000, -1);
      do_conv(16'h00FF, 5);
      check("ignored_start", 32'(bcd_out), 32'h00255);
      do_conv(16'h1234, -1);

      // Abort mid-conversion with reset.
      @(negedge clk);
      start = 1'b1;
      product_in = 16'h3039;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_bcd", 32'(bcd_out), 32'd0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      do_conv(16'h3039, -1);
      check("bcd_12345", 32'(bcd_out), 32'h12345);

      for (int n = 0; n < 20; n++) begin
         do_conv(16'($urandom_range(0, 65535)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
Downstream display stage for the 8x8 shift-add multiplier. It captures the 16-bit product {A,B} when the multiplier finishes and converts it iteratively (double-dabble, one bit per clock) into sign plus packed BCD digits. The BCD result drives the board's hex displays.

Parameters:
WIDTH, 16, bit width of product_in
DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1

Ports:
clk  input  1  system clock; all state updates on posedge
reset_n  input  1  reset, synchronous, active-low
start  input  1  request conversion of product_in; sampled on posedge
product_in  input  WIDTH  product value {A,B} from the multiplier
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when a new result is written
valid  output  1  high once a result is held; low after reset
sign_out  output  1  1 = result negative (signed mode only)
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0]

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, busy=0, done=0, valid=0, sign_out=0, bcd_out=0, scratch registers cleared. Reset mid-conversion aborts the conversion; no done pulse is produced.
- States: IDLE, CONVERT.
- IDLE: if start=1 at edge E0:
  - capture magnitude of product_in into shift register SR and the sign into an internal sign flag;
  - clear BCD accumulator; bit counter=WIDTH; go to CONVERT; busy=1 from E0.
  - If start=0, hold outputs.
- CONVERT, each edge E1..E_WIDTH:
  - every accumulator digit >=5 gets +3;
  - then shift {accumulator, SR} left one bit;
  - decrement counter.
- On edge E_WIDTH (counter reaching 0), the final shifted value is written to bcd_out; sign_out gets the sign flag; valid=1; done=1; busy=0; state=IDLE.
- Latency: WIDTH clock edges from the start-sampling edge to outputs updated. Default WIDTH=16 gives 16 cycles.
- done is high for exactly one cycle, following E_WIDTH, and clears on the next edge.
- start while busy=1: ignored. There is no queuing, and product_in is not resampled.
- Earliest re-accept is the edge after E_WIDTH, when busy=0. A start held high continuously retriggers every WIDTH+1 edges.
- bcd_out and sign_out change only at completion. They are stable during CONVERT and show the previous result.
- Width rule: magnitude is treated as an unsigned WIDTH-bit value, so the most negative input converts correctly (0x8000 -> 32768). The accumulator is 4*DIGITS bits.
- Zero input gives sign_out=0 and bcd_out=0. Negative zero is not possible.

Optional Feature:
- Macro: PRODUCT_BCD_SIGNED_EN.
- Defined:
  - product_in is two's complement;
  - if product_in[WIDTH-1]=1, the magnitude is the two's-complement negation of product_in;
  - sign_out reflects the input sign.
- Undefined:
  - product_in is unsigned;
  - magnitude = product_in;
  - sign_out is tied to 0;
  - no negation logic is built.

Test Plan:
- Reset low for 2 cycles, then release -> busy=0, done=0, valid=0, bcd_out=0x00000, sign_out=0.
- start with product_in=0xFFEB (7 x -3), signed build -> busy for 16 cycles, single done pulse, sign_out=1, bcd_out=0x00021, valid=1.
- start with product_in=0xFFFF -> signed build: sign_out=1, bcd_out=0x00001; unsigned build: sign_out=0, bcd_out=0x65535.
- start with product_in=0x8000, signed build -> sign_out=1, bcd_out=0x32768.
- start with product_in=0x00FF, then start with product_in=0x1234 at cycle 5 while busy -> second start ignored; result bcd_out=0x00255 after 16 cycles; next start is accepted only after busy falls.
- start with product_in=0x3039, reset_n=0 at cycle 8 -> no done pulse, busy=0, valid=0, bcd_out=0. A new start with 0x3039 then yields bcd_out=0x12345.
